// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 4x4 keypad by walking an active-low row drive,
// debounces press and release using an external timer handshake, and reports
// one decoded hex key per accepted press.
module keypad_scan_ctrl #(
    parameter logic [15:0] SCAN_DIV = 16'd4800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       reset_count,
    input  logic       count_done,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic [15:0] dwell_q, dwell_d;
    logic [3:0]  rows_q, rows_d;
    logic [3:0]  code_q, code_d;
    logic        kv_q, kv_d;
    logic        held_q, held_d;
    logic        rc_q, rc_d;
    logic        rcDly_q;
    logic [3:0]  meta_q, cs_q;

    logic        doneOk;
    logic        colOpen;
    logic        hit;
    logic [1:0]  hitCol;

    // Translate a (row, column) position into the hex legend printed on the key.
    function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] value;
        case ({r, c})
            4'b00_00: value = 4'h1;
            4'b00_01: value = 4'h2;
            4'b00_10: value = 4'h3;
            4'b00_11: value = 4'hA;
            4'b01_00: value = 4'h4;
            4'b01_01: value = 4'h5;
            4'b01_10: value = 4'h6;
            4'b01_11: value = 4'hB;
            4'b10_00: value = 4'h7;
            4'b10_01: value = 4'h8;
            4'b10_10: value = 4'h9;
            4'b10_11: value = 4'hC;
            4'b11_00: value = 4'hE;
            4'b11_01: value = 4'h0;
            4'b11_10: value = 4'hF;
            default:  value = 4'hD;
        endcase
        return value;
    endfunction

    // Two-flop synchronizer for the asynchronous column pins; idles at all-open.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 4'hF;
            cs_q   <= 4'hF;
        end else begin
            meta_q <= cols;
            cs_q   <= meta_q;
        end
    end

    // A column pattern only counts as a press when exactly one line is pulled low.
    always_comb begin
        hit    = 1'b0;
        hitCol = 2'd0;
        case (cs_q)
            4'b1110: begin hit = 1'b1; hitCol = 2'd0; end
            4'b1101: begin hit = 1'b1; hitCol = 2'd1; end
            4'b1011: begin hit = 1'b1; hitCol = 2'd2; end
            4'b0111: begin hit = 1'b1; hitCol = 2'd3; end
            default: begin hit = 1'b0; hitCol = 2'd0; end
        endcase
    end

    // The timer needs the pulse cycle and one more to clear, so done is masked then.
    assign doneOk  = count_done & ~rc_q & ~rcDly_q;
    assign colOpen = cs_q[col_q];

    // Next-state logic: scan, debounce the press, hold, debounce the release.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        code_d  = code_q;
        kv_d    = 1'b0;
        rc_d    = 1'b0;
        case (state_q)
            SCAN: begin
                if (dwell_q == SCAN_DIV - 16'd1) begin
                    dwell_d = 16'd0;
                    if (hit) begin
                        col_d   = hitCol;
                        rc_d    = 1'b1;
                        state_d = DB_PRESS;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            DB_PRESS: begin
                if (colOpen) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    dwell_d = 16'd0;
                end else if (doneOk) begin
                    state_d = HELD;
                    code_d  = keyMap(row_q, col_q);
                    kv_d    = 1'b1;
                end
            end
            HELD: begin
                if (colOpen) begin
                    state_d = DB_RELEASE;
                    rc_d    = 1'b1;
                end
            end
            DB_RELEASE: begin
                if (!colOpen) begin
                    state_d = HELD;
                end else if (doneOk) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    dwell_d = 16'd0;
                end
            end
            default: begin
                state_d = SCAN;
                row_d   = 2'd0;
                dwell_d = 16'd0;
            end
        endcase
        held_d = (state_d == HELD) || (state_d == DB_RELEASE);
        rows_d = ~(4'b0001 << row_d);
    end

    // State and registered outputs; async reset restarts scanning at row 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCAN;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            dwell_q <= 16'd0;
            rows_q  <= 4'b1110;
            code_q  <= 4'h0;
            kv_q    <= 1'b0;
            held_q  <= 1'b0;
            rc_q    <= 1'b0;
            rcDly_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            rows_q  <= rows_d;
            code_q  <= code_d;
            kv_q    <= kv_d;
            held_q  <= held_d;
            rc_q    <= rc_d;
            rcDly_q <= rc_q;
        end
    end

    assign rows        = rows_q;
    assign key_code    = code_q;
    assign key_valid   = kv_q;
    assign key_held    = held_q;
    assign reset_count = rc_q;

endmodule
